// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: drives four LEDs in COUNT, BLINK or CHASE mode,
// passing through a FLASH acknowledge on every mode change.
module led_mode_sequencer #(
  parameter int TICK_DIV    = 12_500_000,
  parameter int FLASH_TICKS = 3
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       step_pulse,
  input  logic       mode_pulse,
  input  logic       pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       busy
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);
  typedef enum logic [1:0] {COUNT, BLINK, CHASE, FLASH} state_t;
  state_t state_q, state_d, next_q, next_d;
  logic [3:0] led_q, led_d, count_q, count_d;
  logic dir_q, dir_d, tick;
  logic [PW-1:0] pre_q, pre_d;
  logic [FW-1:0] flash_q, flash_d;
  always_comb begin
    tick = pre_q == PRE_MAX && !pause;
    state_d = state_q;
    next_d = next_q;
    led_d = led_q;
    count_d = count_q;
    dir_d = dir_q;
    flash_d = flash_q;
    pre_d = pause ? pre_q : tick ? '0 : pre_q + 1'b1;
    case (state_q)
      COUNT: begin
        count_d = count_q + {3'b000, step_pulse};
        led_d = count_d;
      end
      BLINK: led_d = tick ? ~led_q : led_q;
      CHASE: begin
        led_d = !tick ? led_q : dir_q ? {led_q[0], led_q[3:1]} : {led_q[2:0], led_q[3]};
        dir_d = dir_q ^ step_pulse;
      end
      FLASH: if (tick) begin
        flash_d = flash_q + 1'b1;
        if (flash_q == FLASH_LAST) begin
          state_d = next_q;
          led_d = next_q == COUNT ? count_q : next_q == BLINK ? 4'b0000 : 4'b0001;
          pre_d = '0;
        end
      end
      default: state_d = COUNT;
    endcase
    // FLASH ignores mode_pulse, so a request there is simply dropped
    if (mode_pulse && state_q != FLASH) begin
      state_d = FLASH;
      next_d = state_q == CHASE ? COUNT : state_q == BLINK ? CHASE : BLINK;
      led_d = 4'b1111;
      flash_d = '0;
      pre_d = '0;
    end
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= COUNT;
      next_q <= COUNT;
      led_q <= '0;
      count_q <= '0;
      dir_q <= 1'b0;
      pre_q <= '0;
      flash_q <= '0;
    end else begin
      state_q <= state_d;
      next_q <= next_d;
      led_q <= led_d;
      count_q <= count_d;
      dir_q <= dir_d;
      pre_q <= pre_d;
      flash_q <= flash_d;
    end
  end
  assign led = led_q;
  assign mode = state_q;
  assign busy = state_q == FLASH;
endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
- Mode controller for the board's 4 user LEDs; replaces the direct count-to-LED path in top.
- Consumes single-cycle debounced button pulses and time-multiplexes the LEDs between three display modes: COUNT, BLINK and CHASE.
- Every mode change passes through a FLASH acknowledge state.
- All timing is derived from an internal tick prescaler on sysclk.

Parameters:
- TICK_DIV, 12_500_000, sysclk cycles per tick (10 Hz at 125 MHz); legal range >= 2.
- FLASH_TICKS, 3, number of ticks spent in FLASH; legal range >= 1.

Ports:
- sysclk  input  1  system clock; every register is clocked on its rising edge.
- reset  input  1  synchronous, active-high reset.
- step_pulse  input  1  one-cycle debounced pulse. Increments the count in COUNT mode; reverses the chase direction in CHASE mode.
- mode_pulse  input  1  one-cycle debounced pulse; requests a move to the next mode.
- pause  input  1  level; while high, the prescaler holds and no ticks are generated.
- led  output  4  registered LED drive.
- mode  output  2  current state: 0=COUNT, 1=BLINK, 2=CHASE, 3=FLASH.
- busy  output  1  high while in FLASH.

Behaviour:
- Reset values: mode=0 (COUNT), led=4'b0000, busy=0, count=0, dir=left, prescaler=0, flash_cnt=0, next_mode=0.
- Reset wins over every other input and takes effect from any state, including mid-FLASH.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick is internal and asserts for the single cycle when prescaler==TICK_DIV-1 and pause==0; the prescaler wraps to 0 on that cycle.
  - pause=1 holds the prescaler value; counting resumes from the held value.
  - The prescaler clears to 0 on every state entry, so the first tick in a state arrives TICK_DIV cycles after entry.
- count:
  - 4-bit register, wraps 15->0.
  - Changes only on step_pulse while in COUNT.
  - Retained across mode changes; cleared only by reset.
- State COUNT:
  - led=count, registered; a step_pulse in cycle N shows on led at N+1.
  - Ticks are ignored.
- State BLINK:
  - Entry led=4'b0000.
  - Each tick toggles led between 4'b0000 and 4'b1111.
  - step_pulse is ignored.
- State CHASE:
  - Entry led=4'b0001.
  - Each tick rotates one-hot: left 0001->0010->0100->1000->0001; right is the reverse order.
  - step_pulse toggles dir and takes effect at the next tick; led does not change on the pulse itself.
  - dir is retained across mode changes.
- Entering FLASH:
  - A mode_pulse in COUNT, BLINK or CHASE at cycle N loads next_mode=(current+1) mod 3, i.e. COUNT->BLINK->CHASE->COUNT.
  - At N+1: mode=3, led=4'b1111, busy=1, flash_cnt=0, prescaler=0.
- State FLASH:
  - Each tick increments flash_cnt.
  - On the tick where flash_cnt==FLASH_TICKS-1, the next cycle enters next_mode with that mode's entry led value; COUNT shows the current count.
  - FLASH duration is FLASH_TICKS*TICK_DIV cycles when pause is low; pause extends it.
  - mode_pulse and step_pulse during FLASH are dropped, not queued.
- Simultaneous step_pulse and mode_pulse in COUNT: both act. count increments and FLASH is entered; the new count is shown on the next COUNT entry.
- Simultaneous step_pulse and mode_pulse in CHASE: dir toggles and FLASH is entered.
- Unused encodings are unreachable; if one is reached, the next cycle goes to COUNT.
- No combinational path from inputs to outputs.

Test Plan (TICK_DIV=4, FLASH_TICKS=2 unless stated):
- Reset, then 17 step_pulses spaced 2 cycles apart -> led=4'b0001 one cycle after the last pulse; mode=0 throughout.
- In COUNT, mode_pulse at cycle N -> N+1: mode=3, led=1111, busy=1; N+9: mode=1, led=0000, busy=0; N+13: led=1111; N+17: led=0000.
- Enter CHASE -> led 0001,0010,0100 on successive ticks. step_pulse while led=0100 -> led unchanged on the pulse; next tick 0010, then 0001, then 1000.
- In BLINK, assert pause when prescaler=2 and hold 20 cycles -> led constant, no ticks. Release -> next toggle 2 cycles after release.
- In COUNT with count=5, step_pulse and mode_pulse in the same cycle -> FLASH entered. A mode_pulse during FLASH is ignored (still exits to BLINK). Cycling BLINK->CHASE->COUNT -> led=0110 on COUNT entry.
- Reset asserted mid-FLASH with count=9 -> next cycle: mode=0, led=0000, busy=0, count=0; the following step_pulse gives led=0001.
